// File: rtl/serial_word_shifter_pkg.sv
// Shared definitions for the serial word shifter.
// FSM encoding and default parameter values.
package serial_word_shifter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam int   DEF_WIDTH      = 8;
    localparam logic DEF_IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/serial_word_shifter.sv
// Parallel-to-serial source stage feeding the sequence detector.
// One word in flight; back-to-back words stream with no gap.
module serial_word_shifter
    import serial_word_shifter_pkg::*;
#(
    parameter int   WIDTH      = DEF_WIDTH,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = DEF_IDLE_LEVEL
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             so,
    output logic             so_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             so_q, so_d;
    logic             so_valid_q, so_valid_d;
    logic             word_done_q, word_done_d;
    logic             load_ready_q, load_ready_d;

    logic             accept;
    logic             last_bit;
    logic [WIDTH-1:0] shreg_nxt;
    logic             head_new;
    logic             head_nxt;

    assign accept   = load_valid && load_ready_q;
    assign last_bit = (state_q == ST_SHIFT) && (cnt_q == LAST);

    // Shifted word and the bit that leaves it next, per bit order.
    always_comb begin
        if (MSB_FIRST) begin
            shreg_nxt = {shreg_q[WIDTH-2:0], 1'b0};
            head_nxt  = shreg_q[WIDTH-2];
            head_new  = load_data[WIDTH-1];
        end else begin
            shreg_nxt = {1'b0, shreg_q[WIDTH-1:1]};
            head_nxt  = shreg_q[1];
            head_new  = load_data[0];
        end
    end

    // Next-state, counter, shift register and output bit selection.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        so_d        = IDLE_LEVEL;
        so_valid_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d    = ST_SHIFT;
                    cnt_d      = '0;
                    shreg_d    = load_data;
                    so_d       = head_new;
                    so_valid_d = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (last_bit) begin
                    if (accept) begin
                        cnt_d      = '0;
                        shreg_d    = load_data;
                        so_d       = head_new;
                        so_valid_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        shreg_d = '0;
                    end
                end else begin
                    cnt_d      = cnt_q + 1'b1;
                    shreg_d    = shreg_nxt;
                    so_d       = head_nxt;
                    so_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        word_done_d  = so_valid_d && (cnt_d == LAST);
        load_ready_d = (state_d == ST_IDLE) || (cnt_d == LAST);
    end

    // State and registered outputs; reset discards any word in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            shreg_q      <= '0;
            so_q         <= IDLE_LEVEL;
            so_valid_q   <= 1'b0;
            word_done_q  <= 1'b0;
            load_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            so_q         <= so_d;
            so_valid_q   <= so_valid_d;
            word_done_q  <= word_done_d;
            load_ready_q <= load_ready_d;
        end
    end

    assign load_ready = load_ready_q;
    assign so         = so_q;
    assign so_valid   = so_valid_q;
    assign word_done  = word_done_q;
    assign busy       = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_serial_word_shifter.sv
// Scoreboard bench for serial_word_shifter.
// Two instances: MSB-first (u0) and LSB-first (u1).
module tb_serial_word_shifter;

    logic clk;
    logic rst_n;
    logic [7:0] ld0, ld1;
    logic lv0, lv1;
    logic lr0, lr1, so0, so1, sv0, sv1, wd0, wd1, bz0, bz1;

    typedef struct {
        logic b;
        logic d;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int total = 0;
    int bad = 0;
    int run0 = 0;
    int last_run0 = 0;
    int hits = 0;
    logic [2:0] hist = 3'b000;

    serial_word_shifter #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .load_data(ld0), .load_valid(lv0),
        .load_ready(lr0), .so(so0), .so_valid(sv0), .word_done(wd0), .busy(bz0)
    );

    serial_word_shifter #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .load_data(ld1), .load_valid(lv1),
        .load_ready(lr1), .so(so1), .so_valid(sv1), .word_done(wd1), .busy(bz1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference: word -> ordered bit list, done flag on the last bit.
    task automatic expect_word(input int dut, input logic [7:0] d);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            e.b = (dut == 0) ? d[7 - i] : d[i];
            e.d = (i == 7);
            if (dut == 0) q0.push_back(e);
            else q1.push_back(e);
        end
    endtask

    // Called just after a falling edge; returns just after the accepting edge's next fall.
    task automatic send(input int dut, input logic [7:0] d);
        int n;
        n = 0;
        if (dut == 0) begin ld0 = d; lv0 = 1'b1; end
        else begin ld1 = d; lv1 = 1'b1; end
        while (((dut == 0) ? lr0 : lr1) !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL send_timeout: load_ready stayed %0b, required 1", (dut == 0) ? lr0 : lr1);
        end else begin
            expect_word(dut, d);
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        #1;
        chk("drain_queues_empty", q0.size() + q1.size(), 0);
    endtask

    // Monitor for u0: pop and compare every data bit, check idle level otherwise.
    always @(negedge clk) begin
        exp_t e;
        hist = {hist[1:0], so0};
        if (hist == 3'b101) hits++;
        total++;
        if (sv0 === 1'b1) begin
            run0++;
            if (q0.size() == 0) begin
                bad++;
                $display("FAIL u0_unexpected_bit: so=%0b so_valid=1, required no bit", so0);
            end else begin
                e = q0.pop_front();
                if (so0 !== e.b || wd0 !== e.d) begin
                    bad++;
                    $display("FAIL u0_bit: so=%0b word_done=%0b, required so=%0b word_done=%0b",
                             so0, wd0, e.b, e.d);
                end
            end
        end else begin
            if (run0 != 0) last_run0 = run0;
            run0 = 0;
            if (so0 !== 1'b0 || wd0 !== 1'b0 || sv0 !== 1'b0) begin
                bad++;
                $display("FAIL u0_idle: so=%0b word_done=%0b so_valid=%0b, required 0 0 0",
                         so0, wd0, sv0);
            end
        end
    end

    // Monitor for u1.
    always @(negedge clk) begin
        exp_t e;
        total++;
        if (sv1 === 1'b1) begin
            if (q1.size() == 0) begin
                bad++;
                $display("FAIL u1_unexpected_bit: so=%0b so_valid=1, required no bit", so1);
            end else begin
                e = q1.pop_front();
                if (so1 !== e.b || wd1 !== e.d) begin
                    bad++;
                    $display("FAIL u1_bit: so=%0b word_done=%0b, required so=%0b word_done=%0b",
                             so1, wd1, e.b, e.d);
                end
            end
        end else if (so1 !== 1'b0 || wd1 !== 1'b0 || sv1 !== 1'b0) begin
            bad++;
            $display("FAIL u1_idle: so=%0b word_done=%0b so_valid=%0b, required 0 0 0",
                     so1, wd1, sv1);
        end
    end

    initial begin
        int h0;
        int extra;
        logic [7:0] r;
        rst_n = 1'b0;
        lv0 = 1'b1;
        lv1 = 1'b1;
        ld0 = 8'h5A;
        ld1 = 8'h5A;

        // Reset held with load_valid high.
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("rst_so", so0, 0);
            chk("rst_so_valid", sv0, 0);
            chk("rst_load_ready", lr0, 0);
            chk("rst_busy", bz0, 0);
        end
        rst_n = 1'b1;
        lv0 = 1'b0;
        lv1 = 1'b0;
        #1;
        chk("rel_load_ready_before_edge", lr0, 0);
        @(negedge clk);
        #1;
        chk("rel_load_ready_after_edge", lr0, 1);
        chk("rel_load_ready_u1", lr1, 1);
        @(negedge clk);

        // Single word, MSB first.
        send(0, 8'hA5);
        lv0 = 1'b0;
        chk("single_busy", bz0, 1);
        drain();
        chk("single_after_so_valid", sv0, 0);
        chk("single_after_load_ready", lr0, 1);
        chk("single_after_busy", bz0, 0);

        // Back-to-back.
        send(0, 8'hF0);
        send(0, 8'h0F);
        lv0 = 1'b0;
        drain();
        @(negedge clk);
        #1;
        chk("b2b_contiguous_run", last_run0, 16);

        // Busy rejection.
        send(0, 8'hFF);
        lv0 = 1'b0;
        repeat (3) @(negedge clk);
        ld0 = 8'h33;
        lv0 = 1'b1;
        #1;
        chk("rej_load_ready_low", lr0, 0);
        @(negedge clk);
        lv0 = 1'b0;
        while (bz0 === 1'b1) begin
            #1;
            chk("rej_ready_only_last", lr0, wd0);
            @(negedge clk);
        end
        drain();

        // Chain pattern: one "101" in the stream.
        repeat (3) @(negedge clk);
        h0 = hits;
        send(0, 8'b00101000);
        lv0 = 1'b0;
        drain();
        repeat (2) @(negedge clk);
        chk("chain_detect_once", hits - h0, 1);

        // LSB first instance.
        send(1, 8'hA5);
        lv1 = 1'b0;
        drain();
        send(1, 8'h1E);
        lv1 = 1'b0;
        drain();

        // Random words with random gaps.
        for (int i = 0; i < 30; i++) begin
            r = 8'($urandom);
            send(0, r);
            extra = $urandom_range(0, 2);
            if (extra != 0) begin
                lv0 = 1'b0;
                repeat (extra) @(negedge clk);
            end
        end
        lv0 = 1'b0;
        drain();

        // Reset mid-word.
        send(0, 8'hC3);
        lv0 = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_so", so0, 0);
        chk("midrst_so_valid", sv0, 0);
        chk("midrst_word_done", wd0, 0);
        chk("midrst_busy", bz0, 0);
        chk("midrst_load_ready", lr0, 0);
        q0.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            #1;
            if (sv0 === 1'b1) extra++;
        end
        chk("midrst_no_bits_after", extra, 0);
        chk("midrst_ready_back", lr0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation ran past limit");
        $fatal(1, "timeout");
    end

endmodule
